y86_imem_loader: RTL

//  Write side of the instruction memory the processor reads from: accepts a framed byte stream,

---
 rtl/y86_pkg.sv | 29 ++
 rtl/loader_timeout.sv | 18 +
 rtl/y86_imem_loader.sv | 111 +++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 constants, loader frame magic, loader states and error codes
package y86_pkg;
  localparam logic [7:0] LOADER_MAGIC = 8'hA5;
  typedef enum logic [2:0] {
    LD_IDLE,
    LD_ADDR_HI,
    LD_ADDR_LO,
    LD_LEN_HI,
    LD_LEN_LO,
    LD_DATA,
    LD_CSUM
  } loader_state_e;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: idle-cycle counter that expires after TIMEOUT_CYCLES cycles without a kick
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic kick,
  output logic expired
);
  localparam int unsigned CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
  // count idle cycles while running; any beat, stop or expiry restarts from zero
  always_ff @(posedge clk)
    cnt <= (reset || !run || kick || expired) ? '0 : cnt + 1'b1;
  assign expired = (TIMEOUT_CYCLES != 0) && run && !kick && (cnt == LAST);
endmodule

// File: rtl/y86_imem_loader.sv
// y86_imem_loader: framed byte stream to instruction RAM writer with checksum-gated processor release
module y86_imem_loader
  import y86_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter bit          HOLD_AT_RESET  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              boot_pulse,
  output logic [1:0]        err_code
);
  localparam int unsigned MEM_BYTES = 1 << ADDR_W;
  loader_state_e state, state_d;
  logic [7:0]        addr_hi, len_hi, sum;
  logic [ADDR_W-1:0] ptr;
  logic [15:0]       remaining, len;
  logic              beat, expired, too_long;
  assign in_ready = 1'b1;
  assign beat     = in_valid;
  assign len      = {len_hi, in_data};
  assign too_long = 32'(len) > MEM_BYTES;
  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .run     (state != LD_IDLE),
    .kick    (beat),
    .expired (expired)
  );
  // state register
  always_ff @(posedge clk)
    state <= reset ? LD_IDLE : state_d;
  // next state: beats advance the frame, an expiry without a beat abandons it
  always_comb begin
    state_d = state;
    if (beat)
      case (state)
        LD_IDLE:    state_d = in_data == LOADER_MAGIC ? LD_ADDR_HI : LD_IDLE;
        LD_ADDR_HI: state_d = LD_ADDR_LO;
        LD_ADDR_LO: state_d = LD_LEN_HI;
        LD_LEN_HI:  state_d = LD_LEN_LO;
        LD_LEN_LO:  state_d = too_long ? LD_IDLE : (len == 16'd0 ? LD_CSUM : LD_DATA);
        LD_DATA:    state_d = remaining == 16'd1 ? LD_CSUM : LD_DATA;
        default:    state_d = LD_IDLE;
      endcase
    else if (expired)
      state_d = LD_IDLE;
  end
  // datapath and status: write port registered one cycle after each payload beat
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wen    <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= HOLD_AT_RESET;
      done       <= 1'b0;
      boot_pulse <= 1'b0;
      err_code   <= ERR_NONE;
      addr_hi    <= '0;
      len_hi     <= '0;
      sum        <= '0;
      ptr        <= '0;
      remaining  <= '0;
    end else begin
      mem_wen    <= 1'b0;
      boot_pulse <= 1'b0;
      if (expired) err_code <= ERR_TMO;
      if (beat)
        case (state)
          LD_IDLE:
            if (in_data == LOADER_MAGIC) begin
              cpu_hold <= 1'b1;
              done     <= 1'b0;
              err_code <= ERR_NONE;
              sum      <= '0;
            end
          LD_ADDR_HI: addr_hi <= in_data;
          LD_ADDR_LO: ptr <= ADDR_W'({addr_hi, in_data});
          LD_LEN_HI:  len_hi <= in_data;
          LD_LEN_LO: begin
            remaining <= len;
            if (too_long) err_code <= ERR_LEN;
          end
          LD_DATA: begin
            mem_wen   <= 1'b1;
            mem_waddr <= ptr;
            mem_wdata <= in_data;
            ptr       <= ptr + 1'b1;
            sum       <= sum + in_data;
            remaining <= remaining - 16'd1;
          end
          default:
            if (in_data == sum) begin
              done       <= 1'b1;
              cpu_hold   <= 1'b0;
              boot_pulse <= 1'b1;
            end else
              err_code <= ERR_CSUM;
        endcase
    end
  end
endmodule
